// File: rtl/rk8e_break_arbiter.sv
// ---------------------------------------------------------------------------
// rk8e_break_arbiter: round-robin sharing of the CPU data-break channel. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rk8e_break_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*15-1:0] req_addr,
   input  logic [NREQ*12-1:0] req_wdata,
   output logic [NREQ-1:0]    req_done,
   output logic [NREQ-1:0]    req_err,
   output logic [11:0]        rdata,
   output logic [14:0]        dmaAddr,
   output logic [11:0]        dmaDout,
   output logic               data_break_write,
   output logic               data_break_read,
   input  logic               break_in_prog,
   input  logic [11:0]        dmaDIN,
   output logic               busy,
   output logic [1:0]         owner
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_BRK  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
   localparam logic [1:0]  LAST_RST = 2'(NREQ - 1);

   state_t            state_q;
   logic              run_q;
   logic [1:0]        last_q;
   logic [11:0]       cnt_q;
   logic [11:0]       cnt_d;
   logic              dir_q;
   logic [NREQ-1:0]   done_q;
   logic [NREQ-1:0]   err_q;
   logic [11:0]       rdata_q;
   logic [14:0]       addr_q;
   logic [11:0]       dout_q;
   logic              dbw_q;
   logic              dbr_q;
   logic              busy_q;
   logic [1:0]        owner_q;

   logic              win_vld_d;
   logic [1:0]        win_idx_d;
   logic [14:0]       win_addr_d;
   logic [11:0]       win_wdata_d;
   logic              win_write_d;
   logic [NREQ-1:0]   owner_oh_d;

   // Walk offsets from farthest to nearest so the nearest valid requester
   // after last_q overwrites the others.
   always_comb begin
      win_vld_d = 1'b0;
      win_idx_d = '0;
      for (int i = NREQ; i >= 1; i--) begin
         for (int r = 0; r < NREQ; r++) begin
            if (r == (int'(last_q) + i) % NREQ && req_valid[r]) begin
               win_vld_d = 1'b1;
               win_idx_d = 2'(r);
            end
         end
      end
   end

   always_comb begin
      win_addr_d  = '0;
      win_wdata_d = '0;
      win_write_d = 1'b0;
      owner_oh_d  = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (win_idx_d == 2'(r)) begin
            win_addr_d  = req_addr[r*15 +: 15];
            win_wdata_d = req_wdata[r*12 +: 12];
            win_write_d = req_write[r];
         end
         if (owner_q == 2'(r)) begin
            owner_oh_d[r] = 1'b1;
         end
      end
   end

   assign cnt_d = cnt_q + 12'd1;

   // run_q gives one edge of grace after reset release before any grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         run_q   <= 1'b0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         dbw_q   <= 1'b0;
         dbr_q   <= 1'b0;
         busy_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         run_q  <= 1'b1;
         done_q <= '0;
         err_q  <= '0;
         if (clear) begin
            state_q <= S_IDLE;
            dbw_q   <= 1'b0;
            dbr_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (run_q && win_vld_d) begin
                     addr_q  <= win_addr_d;
                     dout_q  <= win_wdata_d;
                     dir_q   <= win_write_d;
                     owner_q <= win_idx_d;
                     last_q  <= win_idx_d;
                     dbw_q   <= win_write_d;
                     dbr_q   <= ~win_write_d;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_REQ;
                  end
               end
               S_REQ: begin
                  cnt_q <= cnt_d;
                  if (break_in_prog) begin
                     dbw_q   <= 1'b0;
                     dbr_q   <= 1'b0;
                     state_q <= S_BRK;
                  end else if (cnt_q == TMO_LAST) begin
                     dbw_q   <= 1'b0;
                     dbr_q   <= 1'b0;
                     err_q   <= owner_oh_d;
                     state_q <= S_ERR;
                  end
               end
               S_BRK: begin
                  if (!break_in_prog) begin
                     if (!dir_q) begin
                        rdata_q <= dmaDIN;
                     end
                     done_q  <= owner_oh_d;
                     state_q <= S_DONE;
                  end
               end
               S_DONE, S_ERR: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  dbw_q   <= 1'b0;
                  dbr_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign req_done         = done_q;
   assign req_err          = err_q;
   assign rdata            = rdata_q;
   assign dmaAddr          = addr_q;
   assign dmaDout          = dout_q;
   assign data_break_write = dbw_q;
   assign data_break_read  = dbr_q;
   assign busy             = busy_q;
   assign owner            = owner_q;

endmodule

`default_nettype wire
